i4003_loader: RTL and testbench

Serial driver for a chain of one or more i4003 shift registers. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on `serial_out` and `cp`. Each `cp` phase is stretched well past the i4003's 250 ns internal latch delay. It sits between a CPU-side output port (or test harness) and the i4003 chain, and drives the chain's `enable`. Optionally it captures the bits shifted out of the far end of the chain.

---
 rtl/i4003_loader_if.sv | 29 ++
 rtl/i4003_loader.sv | 214 +++++++++++++++++++++
 tb/tb_i4003_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i4003_loader_if.sv
// i4003_loader_if -- load handshake bundle for i4003_loader.
//   load_data  : word to shift out, bit WIDTH-1 first (master -> slave)
//   load_valid : load request (master -> slave)
//   load_ready : loader idle, a load is accepted on valid & ready (slave -> master)
//   done       : one-cycle pulse when a load has completed (slave -> master)
`timescale 1ns/1ps

interface i4003_loader_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             done;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  done
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output done
    );
endinterface

// File: rtl/i4003_loader.sv
// i4003_loader -- serial driver for a chain of cascaded i4003 shift registers.
// Accepts a parallel word over a valid/ready handshake and shifts it out
// MSB-first on serial_out/cp, with every cp phase stretched to HALF_CY
// system clocks so the i4003 internal latch delay is comfortably met.
//
// Parameters:
//   SYSCLK_TCY : system clock period in ns
//   WIDTH      : total chain length in bits (10 per cascaded i4003)
//   CP_HALF_NS : minimum cp low/high phase in ns (>= 300)
// Ports:
//   sysclk     : system clock, rising edge
//   reset      : synchronous active-high reset
//   bus        : load handshake (load_data, load_valid, load_ready, done)
//   cp         : to every i4003 cp
//   serial_out : to the first i4003 serial_in
//   enable     : to every i4003 enable
//   chain_in   : from the last i4003 serial_out
//   readback   : chain contents captured during the previous load
//
// Optional feature: define I4003_LOADER_READBACK_EN to capture chain_in
// during each shift and present the previous chain contents on readback.
// Without it readback is tied to 0 and chain_in is unused.
`timescale 1ns/1ps

module i4003_loader #(
    parameter int SYSCLK_TCY = 20,
    parameter int WIDTH      = 10,
    parameter int CP_HALF_NS = 500
) (
    input  logic             sysclk,
    input  logic             reset,
    i4003_loader_if.slave    bus,
    output logic             cp,
    output logic             serial_out,
    output logic             enable,
    input  logic             chain_in,
    output logic [WIDTH-1:0] readback
);

    localparam int HALF_CY = (CP_HALF_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int PH_W    = $clog2(HALF_CY + 1);
    localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_CY - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_SETTLE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  w_phase_nxt;
    logic [BIT_W-1:0] r_bit;
    logic [BIT_W-1:0] w_bit_nxt;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_word_nxt;
    logic [WIDTH-1:0] w_word_shl;

    logic r_cp;
    logic w_cp_nxt;
    logic r_so;
    logic w_so_nxt;
    logic r_enable;
    logic w_enable_nxt;
    logic r_done;
    logic w_done_nxt;
    logic r_ready;
    logic w_ready_nxt;

    logic w_phase_end;

    assign w_phase_end = (r_phase == PH_LAST);

    // The shift word is kept MSB-aligned: serial_out always carries word[WIDTH-1],
    // so advancing to the next bit is a left shift rather than a variable index.
    assign w_word_shl = r_word << 1;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_word_nxt  = r_word;
        w_cp_nxt    = 1'b0;
        w_so_nxt    = r_so;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.load_valid) begin
                    w_word_nxt  = bus.load_data;
                    w_so_nxt    = bus.load_data[WIDTH-1];
                    w_bit_nxt   = '0;
                    w_phase_nxt = '0;
                    w_state_nxt = S_SETUP;
                end
            end

            S_SETUP: begin
                if (w_phase_end) begin
                    w_phase_nxt = '0;
                    w_cp_nxt    = 1'b1;
                    w_state_nxt = S_HIGH;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end

            S_HIGH: begin
                w_cp_nxt = 1'b1;
                if (w_phase_end) begin
                    // cp falls here; serial_out moves on the same edge.
                    w_cp_nxt    = 1'b0;
                    w_phase_nxt = '0;
                    if (r_bit != BIT_LAST) begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_word_nxt  = w_word_shl;
                        w_so_nxt    = w_word_shl[WIDTH-1];
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_state_nxt = S_SETTLE;
                    end
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end

            S_SETTLE: begin
                if (w_phase_end) begin
                    w_phase_nxt = '0;
                    w_bit_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = '0;
                w_bit_nxt   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        w_ready_nxt  = (w_state_nxt == S_IDLE);
        w_enable_nxt = (w_state_nxt == S_IDLE) && (r_enable || w_done_nxt);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_bit    <= '0;
            r_word   <= '0;
            r_cp     <= 1'b0;
            r_so     <= 1'b0;
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_bit    <= w_bit_nxt;
            r_word   <= w_word_nxt;
            r_cp     <= w_cp_nxt;
            r_so     <= w_so_nxt;
            r_enable <= w_enable_nxt;
            r_done   <= w_done_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

`ifdef I4003_LOADER_READBACK_EN
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_readback;

    // chain_in is sampled just before each cp rise. Sample i is the old chain
    // bit WIDTH-1-i, so shifting samples in from the LSB leaves sample 0 at
    // the MSB after WIDTH samples and the register holds the old chain word.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_cap      <= '0;
            r_readback <= '0;
        end else begin
            if (r_state == S_SETUP && w_phase_end) begin
                r_cap <= (r_cap << 1) | WIDTH'(chain_in);
            end
            if (r_state == S_SETTLE && w_phase_end) begin
                r_readback <= r_cap;
            end
        end
    end

    assign readback = r_readback;
`else
    logic w_unused_chain_in;

    assign w_unused_chain_in = chain_in;
    assign readback          = '0;
`endif

    assign cp             = r_cp;
    assign serial_out     = r_so;
    assign enable         = r_enable;
    assign bus.load_ready = r_ready;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_i4003_loader.sv
// tb_i4003_loader -- self-checking bench for i4003_loader.
// DUT A: defaults (WIDTH 10, HALF_CY 25). DUT B: cascade (WIDTH 20, HALF_CY 15).
// Each chain is modelled as a plain shift register clocked by the DUT's cp.
`timescale 1ns/1ps

module tb_i4003_loader;

    localparam int WA = 10;
    localparam int HA = 25;
    localparam int WB = 20;
    localparam int HB = 15;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;

    always #10 sysclk = ~sysclk;

    i4003_loader_if #(.WIDTH(WA)) ifa ();
    i4003_loader_if #(.WIDTH(WB)) ifb ();

    logic          cp_a, so_a, en_a;
    logic          cp_b, so_b, en_b;
    logic [WA-1:0] rb_a;
    logic [WB-1:0] rb_b;

    // i4003 chain models: shift on cp rising edge, first-sent bit ends up far end.
    logic [WA-1:0] chain_a = '0;
    logic [WB-1:0] chain_b = '0;

    always @(posedge cp_a) chain_a <= {chain_a[WA-2:0], so_a};
    always @(posedge cp_b) chain_b <= {chain_b[WB-2:0], so_b};

    i4003_loader #(.SYSCLK_TCY(20), .WIDTH(WA), .CP_HALF_NS(500)) dut_a (
        .sysclk     (sysclk),
        .reset      (reset),
        .bus        (ifa.slave),
        .cp         (cp_a),
        .serial_out (so_a),
        .enable     (en_a),
        .chain_in   (chain_a[WA-1]),
        .readback   (rb_a)
    );

    i4003_loader #(.SYSCLK_TCY(20), .WIDTH(WB), .CP_HALF_NS(300)) dut_b (
        .sysclk     (sysclk),
        .reset      (reset),
        .bus        (ifb.slave),
        .cp         (cp_b),
        .serial_out (so_b),
        .enable     (en_b),
        .chain_in   (chain_b[WB-1]),
        .readback   (rb_b)
    );

    // Currently observed DUT: 0 = A, 1 = B.
    logic cur = 1'b0;

    wire        m_cp    = cur ? cp_b : cp_a;
    wire        m_so    = cur ? so_b : so_a;
    wire        m_en    = cur ? en_b : en_a;
    wire        m_ready = cur ? ifb.load_ready : ifa.load_ready;
    wire        m_done  = cur ? ifb.done : ifa.done;
    wire [19:0] m_chain = cur ? chain_b : {10'b0, chain_a};
    wire [19:0] m_rb    = cur ? rb_b : {10'b0, rb_a};

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [19:0] data;
        logic        b2b;
        logic [19:0] nxt;
        logic [19:0] exp_par;
    } vec_t;

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [19:0] d);
        if (cur) begin
            ifb.load_valid = v;
            ifb.load_data  = d;
        end else begin
            ifa.load_valid = v;
            ifa.load_data  = d[9:0];
        end
    endtask

    // Called at a negedge; returns at the negedge of the first SETUP cycle.
    task automatic accept(input logic [19:0] d, input logic keep, input string name);
        int n;
        n = 0;
        drive(1'b1, d);
        while (!m_ready && n < 4000) begin
            @(negedge sysclk);
            n++;
        end
        chk({name, " accept timeout"}, 20'(n < 4000), 20'd1);
        @(posedge sysclk);
        #1;
        if (!keep) drive(1'b0, d);
        @(negedge sysclk);
    endtask

    // Observe one load from its first SETUP cycle (rel=1) to its done cycle.
    task automatic watch(input logic [19:0] d, input int W, input int H,
                         input logic hold, input int poke_rel, input int stop_rel,
                         input logic has_nxt, input logic [19:0] nxt, input string name);
        int          done_rel;
        int          bad_cp, bad_so, bad_busy, done_seen;
        logic [19:0] snap;
        logic [19:0] mask;
        done_rel  = 1 + (2 * W + 1) * H;
        bad_cp    = 0;
        bad_so    = 0;
        bad_busy  = 0;
        done_seen = -1;
        mask      = (W == 20) ? 20'hFFFFF : 20'h003FF;
        snap      = m_chain & mask;
        for (int rel = 1; rel <= done_rel; rel++) begin
            int   k, ph;
            logic sh;
            if (rel == stop_rel) break;
            k  = (rel - 1) / (2 * H);
            ph = (rel - 1) % (2 * H);
            sh = (rel - 1) < 2 * W * H;
            if (m_cp !== (sh && ph >= H)) bad_cp++;
            if (sh && m_so !== d[W-1-k]) bad_so++;
            if (m_done === 1'b1 && done_seen < 0) done_seen = rel;
            if (rel < done_rel && (m_ready !== 1'b0 || m_en !== 1'b0)) bad_busy++;
            if (poke_rel > 0 && rel == poke_rel) drive(1'b1, 20'h00001);
            if (poke_rel > 0 && rel == poke_rel + 1) drive(hold, d);
            if (rel == done_rel) begin
                chk({name, " done cycle"}, 20'(done_seen), 20'(done_rel));
                chk({name, " ready at done"}, 20'(m_ready), 20'd1);
                chk({name, " enable at done"}, 20'(m_en), 20'd1);
                chk({name, " parallel_out"}, (m_en ? m_chain : 20'h0) & mask, d & mask);
`ifdef I4003_LOADER_READBACK_EN
                chk({name, " readback"}, m_rb, snap);
`else
                chk({name, " readback"}, m_rb, 20'h0);
`endif
                if (has_nxt) drive(1'b1, nxt);
            end else begin
                @(negedge sysclk);
            end
        end
        chk({name, " cp waveform errors"}, 20'(bad_cp), 20'd0);
        chk({name, " serial_out errors"}, 20'(bad_so), 20'd0);
        chk({name, " busy ready/enable errors"}, 20'(bad_busy), 20'd0);
    endtask

    task automatic step(input string name);
        @(negedge sysclk);
        chk({name, " done one cycle"}, 20'(m_done), 20'd0);
    endtask

    task automatic do_load(input logic [19:0] d, input int W, input int H,
                           input int poke, input string name);
        accept(d, 1'b0, name);
        watch(d, W, H, 1'b0, poke, -1, 1'b0, 20'h0, name);
        step(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[4];
        logic [19:0] rd;
        vecs[0] = '{data: 20'h2A5, b2b: 1'b0, nxt: 20'h000, exp_par: 20'h2A5};
        vecs[1] = '{data: 20'h3FF, b2b: 1'b1, nxt: 20'h000, exp_par: 20'h000};
        vecs[2] = '{data: 20'h3FF, b2b: 1'b0, nxt: 20'h000, exp_par: 20'h3FF};
        vecs[3] = '{data: 20'h155, b2b: 1'b0, nxt: 20'h000, exp_par: 20'h155};

        drive(1'b0, 20'h0);
        cur = 1'b1;
        drive(1'b0, 20'h0);
        cur = 1'b0;
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b0;
        @(negedge sysclk);

        // Reset state
        chk("reset cp", 20'(cp_a), 20'd0);
        chk("reset serial_out", 20'(so_a), 20'd0);
        chk("reset enable", 20'(en_a), 20'd0);
        chk("reset load_ready", 20'(ifa.load_ready), 20'd1);
        chk("reset done", 20'(ifa.done), 20'd0);
        chk("reset readback", 20'(rb_a), 20'd0);

        // Vector table
        foreach (vecs[i]) begin
            if (vecs[i].b2b) begin
                accept(vecs[i].data, 1'b1, $sformatf("vec%0d a", i));
                watch(vecs[i].data, WA, HA, 1'b1, -10, -1, 1'b1, vecs[i].nxt,
                      $sformatf("vec%0d a", i));
                @(posedge sysclk);
                #1 drive(1'b0, vecs[i].nxt);
                @(negedge sysclk);
                watch(vecs[i].nxt, WA, HA, 1'b0, -10, -1, 1'b0, 20'h0,
                      $sformatf("vec%0d b", i));
                step($sformatf("vec%0d", i));
            end else begin
                do_load(vecs[i].data, WA, HA, -10, $sformatf("vec%0d", i));
            end
            chk($sformatf("vec%0d final chain", i), en_a ? {10'b0, chain_a} : 20'h0,
                vecs[i].exp_par);
        end

        // Busy ignore: a load request mid-shift must not disturb the word.
        do_load(20'h0C3, WA, HA, 100, "busy");

        // Reset mid-operation during bit 4 HIGH (cycles 226..250).
        accept(20'h2A5, 1'b0, "midrst");
        watch(20'h2A5, WA, HA, 1'b0, -10, 230, 1'b0, 20'h0, "midrst");
        reset = 1'b1;
        @(posedge sysclk);
        #1 reset = 1'b0;
        @(negedge sysclk);
        chk("midrst cp", 20'(cp_a), 20'd0);
        chk("midrst serial_out", 20'(so_a), 20'd0);
        chk("midrst enable", 20'(en_a), 20'd0);
        chk("midrst load_ready", 20'(ifa.load_ready), 20'd1);
        chk("midrst done", 20'(ifa.done), 20'd0);
        do_load(20'h0F0, WA, HA, -10, "after reset");

        // Randomised loads against the model
        for (int n = 0; n < 6; n++) begin
            rd = 20'($urandom_range(0, 1023));
            do_load(rd, WA, HA, (n % 2 == 1) ? int'($urandom_range(2, 500)) : -10,
                    $sformatf("rand%0d", n));
        end

        // Cascade of two chips
        cur = 1'b1;
        @(negedge sysclk);
        do_load(20'hABCDE, WB, HB, -10, "cascade");
        chk("cascade chip1", {10'b0, chain_b[9:0]}, 20'h0DE);
        chk("cascade chip2", {10'b0, chain_b[19:10]}, 20'h2AF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
